// File: rtl/wb2avm_pkg.sv
// Shared types and helpers for the Wishbone-classic to Avalon-MM master bridge.
// Holds the state encoding, lane swap helper, legal data widths and watchdog width.
package wb2avm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_RDWAIT = 3'd2,
      ST_ACK    = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_ERR    = 3'd5
   } state_t;

   localparam int unsigned DATA_W_LEGAL [2] = '{32, 64};
   localparam int unsigned TIMEOUT_W = 16;

   // Reverses nb lanes of lw bits each; lw=8 for data, lw=1 for byte enables.
   function automatic logic [63:0] LANE_SWAP(input logic [63:0] d, input int nb, input int lw);
      logic [63:0] r;
      logic [5:0]  src;
      logic [5:0]  dst;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         for (int b = 0; b < 8; b++) begin
            if ((i < nb) && (b < lw)) begin
               src    = 6'((i * lw) + b);
               dst    = 6'(((nb - 1 - i) * lw) + b);
               r[dst] = d[src];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/wb2avm_master_bridge_watchdog.sv
// Transfer watchdog: busy-cycle counter, limit compare and sticky stale-read flag.
// Only instantiated when WB2AVM_TIMEOUT_EN is defined.
module wb2avm_watchdog
   import wb2avm_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr,
   input  logic busy,
   input  logic stale_set,
   input  logic rd_valid,
   output logic timeout,
   output logic stale
);

   logic [TIMEOUT_W-1:0] count_q;
   logic                 stale_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
         stale_q <= 1'b0;
      end else begin
         if (clr)
            count_q <= '0;
         else if (busy)
            count_q <= count_q + 1'b1;
         // A response owed to an abandoned read is swallowed exactly once.
         if (stale_set)
            stale_q <= 1'b1;
         else if (rd_valid)
            stale_q <= 1'b0;
      end
   end

   assign timeout = busy & (count_q == TIMEOUT_W'(TIMEOUT_CYC - 1));
   assign stale   = stale_q;

endmodule

// File: rtl/wb2avm_master_bridge.sv
// Wishbone classic master to pipelined Avalon-MM master bridge, one outstanding transfer.
// Optional watchdog enabled by defining WB2AVM_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for wb_cyc_i & wb_stb_i
// CMD    | avm_read/avm_write asserted until waitrequest drops
// RDWAIT | read accepted, waiting for readdatavalid
// ACK    | one-cycle wb_ack_o
// DRAIN  | aborted read, discarding its readdatavalid
// ERR    | watchdog fired, one-cycle wb_err_o
module wb2avm_master_bridge
   import wb2avm_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter bit          BYTE_SWAP   = 1'b1,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [ADDR_W-1:0]   wb_adr_i,
   input  logic [DATA_W-1:0]   wb_dat_i,
   input  logic [DATA_W/8-1:0] wb_sel_i,
   input  logic                wb_we_i,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   output logic [DATA_W-1:0]   wb_dat_o,
   output logic                wb_ack_o,
   output logic                wb_err_o,
   output logic [ADDR_W-1:0]   avm_address,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [DATA_W/8-1:0] avm_byteenable,
   output logic                avm_read,
   output logic                avm_write,
   input  logic                avm_waitrequest,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_readdatavalid
);

   localparam int NB = int'(DATA_W / 8);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] wdat_q, rdat_q;
   logic [NB-1:0]     sel_q;
   logic              we_q, abort_q;
   logic              wb_req, aborting, rvalid_ok, timeout, stale;
   logic [DATA_W-1:0] wdat_sw, rdat_sw;
   logic [NB-1:0]     sel_sw;

   assign wb_req    = wb_cyc_i & wb_stb_i;
   assign aborting  = abort_q | ~wb_cyc_i;
   assign rvalid_ok = avm_readdatavalid & ~stale;

   assign wdat_sw = BYTE_SWAP ? DATA_W'(LANE_SWAP(64'(wb_dat_i), NB, 8)) : wb_dat_i;
   assign rdat_sw = BYTE_SWAP ? DATA_W'(LANE_SWAP(64'(avm_readdata), NB, 8)) : avm_readdata;
   assign sel_sw  = BYTE_SWAP ? NB'(LANE_SWAP(64'(wb_sel_i), NB, 1)) : wb_sel_i;

`ifdef WB2AVM_TIMEOUT_EN
   logic wd_busy, wd_stale_set;

   assign wd_busy      = (state_q == ST_CMD) | (state_q == ST_RDWAIT) | (state_q == ST_DRAIN);
   assign wd_stale_set = timeout & ~rvalid_ok &
                         ((state_q == ST_RDWAIT) | (state_q == ST_DRAIN));

   wb2avm_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr       (state_q == ST_IDLE),
      .busy      (wd_busy),
      .stale_set (wd_stale_set),
      .rd_valid  (avm_readdatavalid),
      .timeout   (timeout),
      .stale     (stale)
   );

   assign wb_err_o = (state_q == ST_ERR) & ~abort_q;
`else
   assign timeout  = 1'b0;
   assign stale    = 1'b0;
   assign wb_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         adr_q   <= '0;
         wdat_q  <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         rdat_q  <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_IDLE) && wb_req) begin
            adr_q  <= wb_adr_i;
            wdat_q <= wdat_sw;
            sel_q  <= sel_sw;
            we_q   <= wb_we_i;
         end
         if ((state_q == ST_RDWAIT) && rvalid_ok && !aborting)
            rdat_q <= rdat_sw;
         if (state_q == ST_IDLE)
            abort_q <= 1'b0;
         else if (((state_q == ST_CMD) || (state_q == ST_RDWAIT)) && !wb_cyc_i)
            abort_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (wb_req) state_d = ST_CMD;
         // An issued command is never retracted on abort; only the watchdog may drop it.
         ST_CMD: begin
            if (!avm_waitrequest) begin
               if (we_q) state_d = aborting ? ST_IDLE : ST_ACK;
               else      state_d = aborting ? ST_DRAIN : ST_RDWAIT;
            end else if (timeout) begin
               state_d = ST_ERR;
            end
         end
         ST_RDWAIT: begin
            if (rvalid_ok)     state_d = aborting ? ST_IDLE : ST_ACK;
            else if (timeout)  state_d = ST_ERR;
            else if (aborting) state_d = ST_DRAIN;
         end
         ST_ACK:    state_d = ST_IDLE;
         ST_DRAIN: begin
            if (rvalid_ok)    state_d = ST_IDLE;
            else if (timeout) state_d = ST_ERR;
         end
         ST_ERR:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign avm_read       = (state_q == ST_CMD) & ~we_q;
   assign avm_write      = (state_q == ST_CMD) & we_q;
   assign wb_ack_o       = (state_q == ST_ACK);
   assign avm_address    = adr_q;
   assign avm_writedata  = wdat_q;
   assign avm_byteenable = sel_q;
   assign wb_dat_o       = rdat_q;

endmodule

// File: tb/tb_wb2avm_master_bridge.sv
// Directed bench for wb2avm_master_bridge: 32-bit swapped instance and 64-bit straight instance.
module tb_wb2avm_master_bridge;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   // 32-bit, lanes swapped
   logic [31:0] a_adr, a_dat_i, a_dat_o, a_address, a_wdata, a_rdata;
   logic [3:0]  a_sel, a_be;
   logic        a_we, a_cyc, a_stb, a_ack, a_err, a_read, a_write, a_wait, a_rvalid;

   // 64-bit, lanes straight
   logic [31:0] b_adr, b_address;
   logic [63:0] b_dat_i, b_dat_o, b_wdata, b_rdata;
   logic [7:0]  b_sel, b_be;
   logic        b_we, b_cyc, b_stb, b_ack, b_err, b_read, b_write, b_wait, b_rvalid;

   wb2avm_master_bridge #(
      .DATA_W (32), .ADDR_W (32), .BYTE_SWAP (1'b1), .TIMEOUT_CYC (8)
   ) dut_a (
      .clk_i (clk), .rst_i (rst),
      .wb_adr_i (a_adr), .wb_dat_i (a_dat_i), .wb_sel_i (a_sel), .wb_we_i (a_we),
      .wb_cyc_i (a_cyc), .wb_stb_i (a_stb), .wb_dat_o (a_dat_o), .wb_ack_o (a_ack),
      .wb_err_o (a_err), .avm_address (a_address), .avm_writedata (a_wdata),
      .avm_byteenable (a_be), .avm_read (a_read), .avm_write (a_write),
      .avm_waitrequest (a_wait), .avm_readdata (a_rdata), .avm_readdatavalid (a_rvalid)
   );

   wb2avm_master_bridge #(
      .DATA_W (64), .ADDR_W (32), .BYTE_SWAP (1'b0), .TIMEOUT_CYC (8)
   ) dut_b (
      .clk_i (clk), .rst_i (rst),
      .wb_adr_i (b_adr), .wb_dat_i (b_dat_i), .wb_sel_i (b_sel), .wb_we_i (b_we),
      .wb_cyc_i (b_cyc), .wb_stb_i (b_stb), .wb_dat_o (b_dat_o), .wb_ack_o (b_ack),
      .wb_err_o (b_err), .avm_address (b_address), .avm_writedata (b_wdata),
      .avm_byteenable (b_be), .avm_read (b_read), .avm_write (b_write),
      .avm_waitrequest (b_wait), .avm_readdata (b_rdata), .avm_readdatavalid (b_rvalid)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic a_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
      a_we = we; a_adr = adr; a_dat_i = dat; a_sel = sel; a_cyc = 1'b1; a_stb = 1'b1;
   endtask

   task automatic a_drop();
      a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_adr = '0; a_dat_i = '0; a_sel = '0; a_we = 1'b0; a_cyc = 1'b0; a_stb = 1'b0;
      a_wait = 1'b0; a_rdata = '0; a_rvalid = 1'b0;
      b_adr = '0; b_dat_i = '0; b_sel = '0; b_we = 1'b0; b_cyc = 1'b0; b_stb = 1'b0;
      b_wait = 1'b0; b_rdata = '0; b_rvalid = 1'b0;
      #23;
      n_checks++;
      if ({a_read, a_write, a_ack, a_err} !== 4'b0000) begin
         n_errors++; $display("FAIL reset_ctrl_a: got %b want 0000", {a_read, a_write, a_ack, a_err});
      end
      n_checks++;
      if ({a_address, a_wdata, a_be, a_dat_o} !== 100'd0) begin
         n_errors++; $display("FAIL reset_data_a: got %h want 0", {a_address, a_wdata, a_be, a_dat_o});
      end
      n_checks++;
      if ({b_read, b_write, b_ack, b_err, b_be, b_wdata, b_dat_o, b_address} !== 172'd0) begin
         n_errors++; $display("FAIL reset_b: got %h want 0",
                              {b_read, b_write, b_ack, b_err, b_be, b_wdata, b_dat_o, b_address});
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_write_swap();
      next_cycle();                                          // cycle 0
      a_wait = 1'b0;
      a_req(1'b1, 32'h100, 32'h11223344, 4'b0001);
      next_cycle();                                          // cycle 1
      n_checks++;
      if ({a_read, a_write, a_ack} !== 3'b010) begin
         n_errors++; $display("FAIL wr_cmd_ctrl: got %b want 010", {a_read, a_write, a_ack});
      end
      n_checks++;
      if ({a_address, a_wdata, a_be} !== {32'h100, 32'h44332211, 4'b1000}) begin
         n_errors++; $display("FAIL wr_cmd_fields: got %h %h %b want 100 44332211 1000",
                              a_address, a_wdata, a_be);
      end
      next_cycle();                                          // cycle 2
      n_checks++;
      if ({a_read, a_write, a_ack} !== 3'b001) begin
         n_errors++; $display("FAIL wr_ack: got %b want 001", {a_read, a_write, a_ack});
      end
      a_drop();
      next_cycle();                                          // cycle 3
      n_checks++;
      if ({a_read, a_write, a_ack} !== 3'b000) begin
         n_errors++; $display("FAIL wr_ack_single: got %b want 000", {a_read, a_write, a_ack});
      end
   endtask

   task automatic test_read_wait();
      next_cycle();                                          // cycle 0
      a_wait = 1'b1;
      a_req(1'b0, 32'h200, 32'h0, 4'b0011);
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         n_checks++;
         if ({a_read, a_write, a_ack, a_address, a_be} !== {3'b100, 32'h200, 4'b1100}) begin
            n_errors++; $display("FAIL rd_cmd_stable c%0d: got %b %h %b want 100 200 1100",
                                 c, {a_read, a_write, a_ack}, a_address, a_be);
         end
         if (c == 4) a_wait = 1'b0;
      end
      next_cycle();                                          // cycle 5, RDWAIT
      n_checks++;
      if ({a_read, a_ack} !== 2'b00) begin
         n_errors++; $display("FAIL rd_cmd_dropped: got %b want 00", {a_read, a_ack});
      end
      next_cycle();                                          // cycle 6
      a_rvalid = 1'b1; a_rdata = 32'hAABBCCDD;
      next_cycle();                                          // cycle 7
      a_rvalid = 1'b0; a_rdata = 32'h0;
      n_checks++;
      if ({a_ack, a_dat_o} !== {1'b1, 32'hDDCCBBAA}) begin
         n_errors++; $display("FAIL rd_data: got ack=%b %h want ack=1 ddccbbaa", a_ack, a_dat_o);
      end
      a_drop();
      next_cycle();                                          // cycle 8
      n_checks++;
      if ({a_ack, a_dat_o} !== {1'b0, 32'hDDCCBBAA}) begin
         n_errors++; $display("FAIL rd_hold: got ack=%b %h want ack=0 ddccbbaa", a_ack, a_dat_o);
      end
   endtask

   task automatic test_abort_rdwait();
      a_rvalid = 1'b1; a_rdata = 32'h99999999;               // unsolicited in IDLE
      next_cycle();
      a_rvalid = 1'b0;
      next_cycle();
      n_checks++;
      if ({a_ack, a_dat_o} !== {1'b0, 32'hDDCCBBAA}) begin
         n_errors++; $display("FAIL unsolicited_idle: got ack=%b %h want ack=0 ddccbbaa", a_ack, a_dat_o);
      end
      a_wait = 1'b0;
      a_req(1'b0, 32'h300, 32'h0, 4'b1111);                  // cycle 0
      next_cycle();                                          // cycle 1
      next_cycle();                                          // cycle 2, RDWAIT
      a_drop();
      next_cycle();                                          // cycle 3, DRAIN
      a_rvalid = 1'b1; a_rdata = 32'h55667788;
      for (int c = 4; c <= 6; c++) begin
         next_cycle();
         a_rvalid = 1'b0;
         n_checks++;
         if ({a_ack, a_read, a_dat_o} !== {2'b00, 32'hDDCCBBAA}) begin
            n_errors++; $display("FAIL abort_no_ack c%0d: got ack=%b rd=%b %h want 0 0 ddccbbaa",
                                 c, a_ack, a_read, a_dat_o);
         end
      end
      a_req(1'b0, 32'h500, 32'h0, 4'b1111);                  // cycle 0
      next_cycle();                                          // cycle 1
      n_checks++;
      if ({a_read, a_address} !== {1'b1, 32'h500}) begin
         n_errors++; $display("FAIL post_abort_cmd: got %b %h want 1 500", a_read, a_address);
      end
      next_cycle();                                          // cycle 2
      a_rvalid = 1'b1; a_rdata = 32'h0A0B0C0D;
      next_cycle();                                          // cycle 3
      a_rvalid = 1'b0;
      n_checks++;
      if ({a_ack, a_dat_o} !== {1'b1, 32'h0D0C0B0A}) begin
         n_errors++; $display("FAIL post_abort_rd: got ack=%b %h want ack=1 0d0c0b0a", a_ack, a_dat_o);
      end
      a_drop();
      next_cycle();
   endtask

   task automatic test_back_to_back();
      a_wait = 1'b0;
      a_req(1'b1, 32'h10, 32'hCAFEF00D, 4'b0000);            // cycle 0
      next_cycle();                                          // cycle 1
      n_checks++;
      if ({a_write, a_wdata, a_be} !== {1'b1, 32'h0DF0FECA, 4'b0000}) begin
         n_errors++; $display("FAIL b2b_first: got %b %h %b want 1 0df0feca 0000", a_write, a_wdata, a_be);
      end
      next_cycle();                                          // cycle 2, stb held
      n_checks++;
      if (a_ack !== 1'b1) begin
         n_errors++; $display("FAIL b2b_ack1: got %b want 1", a_ack);
      end
      next_cycle();                                          // cycle 3, IDLE
      n_checks++;
      if ({a_write, a_ack} !== 2'b00) begin
         n_errors++; $display("FAIL b2b_idle_gap: got %b want 00", {a_write, a_ack});
      end
      a_req(1'b1, 32'h14, 32'h12345678, 4'b0111);
      next_cycle();                                          // cycle 4
      n_checks++;
      if ({a_write, a_address, a_wdata, a_be} !== {1'b1, 32'h14, 32'h78563412, 4'b1110}) begin
         n_errors++; $display("FAIL b2b_second: got %b %h %h %b want 1 14 78563412 1110",
                              a_write, a_address, a_wdata, a_be);
      end
      next_cycle();                                          // cycle 5
      n_checks++;
      if (a_ack !== 1'b1) begin
         n_errors++; $display("FAIL b2b_ack2: got %b want 1", a_ack);
      end
      a_drop();
      next_cycle();
   endtask

   task automatic test_reset_mid_write();
      a_wait = 1'b1;
      a_req(1'b1, 32'h600, 32'h00000001, 4'b1111);           // cycle 0
      next_cycle();                                          // cycle 1
      n_checks++;
      if (a_write !== 1'b1) begin
         n_errors++; $display("FAIL rstmid_pre: got %b want 1", a_write);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({a_read, a_write, a_ack, a_err, a_address, a_wdata, a_be, a_dat_o} !== 104'd0) begin
         n_errors++; $display("FAIL rstmid_outputs: got %h want 0",
                              {a_read, a_write, a_ack, a_err, a_address, a_wdata, a_be, a_dat_o});
      end
      a_drop(); a_wait = 1'b0;
      next_cycle();
      rst = 1'b0;
      a_rvalid = 1'b1; a_rdata = 32'h12121212;
      next_cycle();
      a_rvalid = 1'b0;
      next_cycle();
      n_checks++;
      if ({a_read, a_write, a_ack, a_dat_o} !== 35'd0) begin
         n_errors++; $display("FAIL rstmid_idle: got %h want 0", {a_read, a_write, a_ack, a_dat_o});
      end
   endtask

`ifdef WB2AVM_TIMEOUT_EN
   task automatic test_timeout();
      a_wait = 1'b0;
      a_req(1'b0, 32'h700, 32'h0, 4'b1111);                  // cycle 0
      for (int c = 1; c <= 8; c++) begin
         next_cycle();
         n_checks++;
         if ({a_err, a_ack} !== 2'b00) begin
            n_errors++; $display("FAIL tmo_early c%0d: got %b want 00", c, {a_err, a_ack});
         end
      end
      next_cycle();                                          // cycle 9
      n_checks++;
      if ({a_err, a_ack, a_read} !== 3'b100) begin
         n_errors++; $display("FAIL tmo_err: got %b want 100", {a_err, a_ack, a_read});
      end
      a_drop();
      next_cycle();                                          // cycle 10
      n_checks++;
      if (a_err !== 1'b0) begin
         n_errors++; $display("FAIL tmo_err_single: got %b want 0", a_err);
      end
      a_rvalid = 1'b1; a_rdata = 32'hEEEEEEEE;               // late response
      next_cycle();
      a_rvalid = 1'b0;
      a_req(1'b0, 32'h704, 32'h0, 4'b1111);                  // cycle 0
      next_cycle();                                          // cycle 1
      next_cycle();                                          // cycle 2
      a_rvalid = 1'b1; a_rdata = 32'h01020304;
      next_cycle();                                          // cycle 3
      a_rvalid = 1'b0;
      n_checks++;
      if ({a_ack, a_dat_o} !== {1'b1, 32'h04030201}) begin
         n_errors++; $display("FAIL tmo_next_rd: got ack=%b %h want ack=1 04030201", a_ack, a_dat_o);
      end
      a_drop();
      next_cycle();
   endtask
`else
   task automatic test_no_watchdog();
      a_wait = 1'b0;
      a_req(1'b0, 32'h700, 32'h0, 4'b1111);
      for (int c = 1; c <= 20; c++) next_cycle();
      n_checks++;
      if ({a_err, a_ack, a_read} !== 3'b000) begin
         n_errors++; $display("FAIL nowd_wait: got %b want 000", {a_err, a_ack, a_read});
      end
      a_rvalid = 1'b1; a_rdata = 32'h01020304;
      next_cycle();
      a_rvalid = 1'b0;
      n_checks++;
      if ({a_err, a_ack, a_dat_o} !== {2'b01, 32'h04030201}) begin
         n_errors++; $display("FAIL nowd_late_rd: got err=%b ack=%b %h want 0 1 04030201",
                              a_err, a_ack, a_dat_o);
      end
      a_drop();
      next_cycle();
   endtask
`endif

   task automatic test_wide_noswap();
      b_wait = 1'b0;
      b_we = 1'b1; b_adr = 32'h1000; b_dat_i = 64'h0102030405060708; b_sel = 8'hF0;
      b_cyc = 1'b1; b_stb = 1'b1;                            // cycle 0
      next_cycle();                                          // cycle 1
      n_checks++;
      if ({b_write, b_address, b_wdata, b_be} !== {1'b1, 32'h1000, 64'h0102030405060708, 8'hF0}) begin
         n_errors++; $display("FAIL wide_wr: got %b %h %h %h want 1 1000 0102030405060708 f0",
                              b_write, b_address, b_wdata, b_be);
      end
      next_cycle();                                          // cycle 2
      n_checks++;
      if (b_ack !== 1'b1) begin
         n_errors++; $display("FAIL wide_wr_ack: got %b want 1", b_ack);
      end
      b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
      next_cycle();
      b_adr = 32'h1008; b_sel = 8'h0F; b_cyc = 1'b1; b_stb = 1'b1;
      next_cycle();                                          // cycle 1
      n_checks++;
      if ({b_read, b_be} !== {1'b1, 8'h0F}) begin
         n_errors++; $display("FAIL wide_rd_cmd: got %b %h want 1 0f", b_read, b_be);
      end
      next_cycle();                                          // cycle 2
      b_rvalid = 1'b1; b_rdata = 64'h1122334455667788;
      next_cycle();                                          // cycle 3
      b_rvalid = 1'b0;
      n_checks++;
      if ({b_ack, b_dat_o} !== {1'b1, 64'h1122334455667788}) begin
         n_errors++; $display("FAIL wide_rd: got ack=%b %h want ack=1 1122334455667788", b_ack, b_dat_o);
      end
      b_cyc = 1'b0; b_stb = 1'b0;
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_write_swap();
      test_read_wait();
      test_abort_rdwait();
      test_back_to_back();
      test_reset_mid_write();
`ifdef WB2AVM_TIMEOUT_EN
      test_timeout();
`else
      test_no_watchdog();
`endif
      test_wide_noswap();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: got no finish want finish before 200000");
      $fatal(1, "time limit");
   end

endmodule
